// File: rtl/cy_stream_pkg.sv
// Shared definitions for the stream packer: lane-count width helper and lane fill value.
package cy_stream_pkg;

  localparam logic LANE_ZERO = 1'b0;

  function automatic int clog2_plus1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cy_pack_lane_ctrl.sv
// Lane counter for the packer: tracks the next lane to fill and flags the beat that closes a word.
module cy_pack_lane_ctrl
  import cy_stream_pkg::*;
#(
  parameter int RATIO = 4,
  parameter int CW    = clog2_plus1(RATIO)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             last,
  output logic [CW-1:0]    cnt,
  output logic [RATIO-1:0] lane,
  output logic             complete
);

  logic at_top;

  assign at_top   = (cnt == CW'(RATIO - 1));
  assign complete = accept && (at_top || last);

  always_comb begin
    lane = '0;
    for (int k = 0; k < RATIO; k++) begin
      lane[k] = (cnt == CW'(k));
    end
  end

  // The counter only returns to zero through a completing beat, so it never reaches RATIO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (complete) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cy_stream_packer.sv
// Packs a narrow valid/ready beat stream into registered wide words, flushing early on i_last.
module cy_stream_packer
  import cy_stream_pkg::*;
#(
  parameter  int IW    = 8,
  parameter  int RATIO = 4,
  localparam int OW    = IW * RATIO,
  localparam int CW    = clog2_plus1(RATIO)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [IW-1:0] i_data,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  logic             accept;
  logic             complete;
  logic [CW-1:0]    cnt;
  logic [RATIO-1:0] lane;
  logic [OW-1:0]    acc;
  logic [OW-1:0]    merged;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;

  cy_pack_lane_ctrl #(
    .RATIO (RATIO),
    .CW    (CW)
  ) u_lane_ctrl (
    .clk      (i_clk),
    .reset    (i_reset),
    .accept   (accept),
    .last     (i_last),
    .cnt      (cnt),
    .lane     (lane),
    .complete (complete)
  );

  // Lanes above the current one are forced empty so a short word never carries stale bytes.
  always_comb begin
    merged = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (lane[k]) begin
        merged[k*IW +: IW] = i_data;
      end else if (CW'(k) < cnt) begin
        merged[k*IW +: IW] = acc[k*IW +: IW];
      end else begin
        merged[k*IW +: IW] = {IW{LANE_ZERO}};
      end
    end
  end

  // A drain and a new completion in the same edge keep o_valid high with the new word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
      o_last  <= 1'b0;
      acc     <= '0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (complete) begin
        o_data  <= merged;
        o_count <= cnt + CW'(1);
        o_last  <= i_last;
        o_valid <= 1'b1;
        acc     <= '0;
      end else if (accept) begin
        for (int k = 0; k < RATIO; k++) begin
          if (lane[k]) begin
            acc[k*IW +: IW] <= i_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cy_stream_packer.sv
// Self-checking bench for cy_stream_packer: directed steps plus random traffic against a queue model.
module tb_cy_stream_packer;

  localparam int IW    = 8;
  localparam int RATIO = 4;
  localparam int OW    = IW * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [IW-1:0] i_data;
  logic          i_last;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic          o_last;

  typedef struct {
    logic [OW-1:0] data;
    int            count;
    bit            last;
  } word_t;

  word_t         exp_q[$];
  logic [IW-1:0] beat_q[$];

  int vec_count  = 0;
  int miss_count = 0;
  int tick_count = 0;
  bit last_accept;

  cy_stream_packer #(
    .IW    (IW),
    .RATIO (RATIO)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_last  (o_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      miss_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model just before the edge, update the model, land on the next negedge.
  task automatic tick();
    bit    exp_valid;
    word_t w;
    #1;
    last_accept = 1'b0;
    if (i_reset) begin
      exp_q.delete();
      beat_q.delete();
    end else begin
      exp_valid = (exp_q.size() != 0);
      checkOutput("o_valid", OW'(o_valid), OW'(exp_valid));
      checkOutput("o_ready", OW'(o_ready), OW'(!exp_valid || i_ready));
      if (exp_valid) begin
        checkOutput("o_data", o_data, exp_q[0].data);
        checkOutput("o_count", OW'(o_count), OW'(exp_q[0].count));
        checkOutput("o_last", OW'(o_last), OW'(exp_q[0].last));
        if (i_ready) void'(exp_q.pop_front());
      end
      if (i_valid && (!exp_valid || i_ready)) begin
        last_accept = 1'b1;
        beat_q.push_back(i_data);
        if (beat_q.size() == RATIO || i_last) begin
          w.data = '0;
          foreach (beat_q[k]) w.data[k*IW +: IW] = beat_q[k];
          w.count = beat_q.size();
          w.last  = i_last;
          exp_q.push_back(w);
          beat_q.delete();
        end
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
    tick_count++;
  endtask

  task automatic applyStimulus(input logic [IW-1:0] d, input logic l);
    int tries = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    do begin
      tick();
      tries++;
    end while (!last_accept && tries < 40);
    checkOutput("beat_accepted", OW'(last_accept), OW'(1'b1));
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, OW'(o_valid), '0);
    checkOutput({tag, "_data"}, o_data, '0);
    checkOutput({tag, "_count"}, OW'(o_count), '0);
    checkOutput({tag, "_last"}, OW'(o_last), '0);
  endtask

  initial begin
    int t0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    tick();
    i_reset = 1'b0;
    checkReset("reset");
    checkOutput("reset_ready", OW'(o_ready), OW'(1'b1));

    // Full word, then it drains the following cycle.
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b0);
    checkOutput("full_valid", OW'(o_valid), OW'(1'b1));
    checkOutput("full_data", o_data, 32'h44332211);
    checkOutput("full_count", OW'(o_count), OW'(4));
    checkOutput("full_last", OW'(o_last), OW'(1'b0));
    tick();
    checkOutput("full_drained", OW'(o_valid), OW'(1'b0));

    // Early flush on the second beat.
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b1);
    checkOutput("flush_data", o_data, 32'h0000BBAA);
    checkOutput("flush_count", OW'(o_count), OW'(2));
    checkOutput("flush_last", OW'(o_last), OW'(1'b1));
    tick();

    // Twelve back-to-back beats must each be accepted on the first try.
    t0 = tick_count;
    for (int i = 1; i <= 12; i++) applyStimulus(IW'(i), 1'b0);
    checkOutput("no_bubbles", OW'(tick_count - t0), OW'(12));
    checkOutput("stream_last_word", o_data, 32'h0C0B0A09);
    tick();

    // Downstream stall holds the word and blocks upstream.
    i_ready = 1'b0;
    applyStimulus(8'hC1, 1'b0);
    applyStimulus(8'hC2, 1'b0);
    applyStimulus(8'hC3, 1'b0);
    applyStimulus(8'hC4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_ready", OW'(o_ready), OW'(1'b0));
      checkOutput("stall_data", o_data, 32'hC4C3C2C1);
      tick();
    end
    i_ready = 1'b1;
    #1;
    checkOutput("release_ready", OW'(o_ready), OW'(1'b1));
    tick();
    checkOutput("release_drained", OW'(o_valid), OW'(1'b0));

    // Single-beat word.
    applyStimulus(8'h5A, 1'b1);
    checkOutput("single_count", OW'(o_count), OW'(1));
    checkOutput("single_data", o_data, 32'h0000005A);
    tick();

    // Reset mid-word discards the partial accumulation.
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checkReset("midreset");
    for (int i = 0; i < 4; i++) applyStimulus(IW'(8'h10 + i), 1'b0);
    checkOutput("after_reset_data", o_data, 32'h13121110);
    checkOutput("after_reset_count", OW'(o_count), OW'(4));
    tick();

    // Random traffic with upstream gaps, early flushes and downstream back-pressure.
    for (int i = 0; i < 400; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = IW'($urandom);
      i_last  = ($urandom_range(0, 4) == 0);
      i_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("all_words_seen", OW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
